// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory_io port between the instruction and data requesters
package mem_port_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
  } memory_io_req;
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] data;
  } memory_io_rsp;
endpackage

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_PRIORITY = 0,
  parameter int MAX_WAIT      = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req inst_req,
  output memory_io_rsp inst_rsp,
  input  memory_io_req data_req,
  output memory_io_rsp data_rsp,
  output memory_io_req mem_req,
  input  memory_io_rsp mem_rsp,
  output logic         busy,
  output logic         timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t       r_state;
  logic         r_owner;
  logic         r_rr_last;
  logic         r_timeout;
  logic [7:0]   r_wait_cnt;
  logic [1:0]   r_full;
  memory_io_req r_slot [2];
  memory_io_req w_req [2];
  memory_io_req w_own;
  logic         w_last;
  logic         w_done;
  logic [1:0]   w_hit;
  logic [31:0]  w_rsp_data;

  assign w_req[0]   = inst_req;
  assign w_req[1]   = data_req;
  assign w_own      = r_slot[r_owner];
  assign w_last     = r_wait_cnt == 8'(MAX_WAIT - 1);
  assign w_done     = r_state == WAIT && (mem_rsp.valid || w_last);
  assign w_hit      = {w_done && r_owner, w_done && !r_owner};
  assign w_rsp_data = mem_rsp.valid ? mem_rsp.data : 32'd0;
  assign busy       = r_state != IDLE || |r_full;
  assign timeout    = r_timeout;

  // route the owner's slot to memory while issuing and the completion back to its owner
  always_comb begin
    mem_req       = r_state == ISSUE ? w_own : '0;
    mem_req.valid = r_state == ISSUE && mem_rsp.ready && w_own.valid;
    inst_rsp      = '{valid: w_hit[0], ready: !r_full[0], data: w_hit[0] ? w_rsp_data : 32'd0};
    data_rsp      = '{valid: w_hit[1], ready: !r_full[1], data: w_hit[1] ? w_rsp_data : 32'd0};
  end

  // per-port request slots: capture when empty, release when the owned transaction completes
  always_ff @(posedge clk)
    if (reset) begin
      r_full    <= '0;
      r_slot[0] <= '0;
      r_slot[1] <= '0;
    end else
      for (int i = 0; i < 2; i++)
        if (w_req[i].valid && !r_full[i]) begin
          r_full[i] <= 1'b1;
          r_slot[i] <= w_req[i];
        end else if (w_hit[i]) r_full[i] <= 1'b0;

  // grant, issue and wait sequencing with the abort counter and sticky timeout flag
  always_ff @(posedge clk)
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_rr_last  <= 1'b0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else
      case (r_state)
        IDLE:
          if (|r_full) begin
            r_owner <= &r_full ? (DATA_PRIORITY != 0 || !r_rr_last) : r_full[1];
            r_state <= ISSUE;
          end
        ISSUE:
          if (mem_rsp.ready) begin
            r_state    <= WAIT;
            r_wait_cnt <= '0;
          end
        WAIT:
          if (w_done) begin
            r_state   <= IDLE;
            r_rr_last <= r_owner;
            if (!mem_rsp.valid) r_timeout <= 1'b1;
          end else r_wait_cnt <= r_wait_cnt + 8'd1;
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors plus scoreboarded corner sequences for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rd;
    logic [3:0]  wr;
  } iss_t;
  typedef struct {
    logic        port;
    logic [31:0] data;
  } rsp_t;
  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rd;
    logic [3:0]  wr;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp_data;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  memory_io_req inst_req, data_req;
  memory_io_rsp mem_rsp;
  memory_io_rsp o0_inst, o0_data, o1_inst, o1_data;
  memory_io_req o0_mem, o1_mem;
  logic         o0_busy, o0_to, o1_busy, o1_to;

  int          n_tests = 0;
  int          n_fail = 0;
  logic        g_ready = 1'b1;
  logic        g_drop = 1'b0;
  logic        g_inject = 1'b0;
  logic        g_flush = 1'b0;
  logic        en1 = 1'b0;
  int          g_lat = 1;
  logic [31:0] g_rdata = '0;
  iss_t        iq[$];
  iss_t        i1q[$];
  rsp_t        rq[$];
  logic        r1q[$];
  vec_t        tbl[5];

  localparam logic [33:0] RSP_RST = {1'b0, 1'b1, 32'd0};

  mem_port_arbiter #(.DATA_PRIORITY(0), .MAX_WAIT(4)) u0 (
    .clk(clk), .reset(reset), .inst_req(inst_req), .inst_rsp(o0_inst),
    .data_req(data_req), .data_rsp(o0_data), .mem_req(o0_mem), .mem_rsp(mem_rsp),
    .busy(o0_busy), .timeout(o0_to)
  );
  mem_port_arbiter #(.DATA_PRIORITY(1), .MAX_WAIT(255)) u1 (
    .clk(clk), .reset(reset), .inst_req(inst_req), .inst_rsp(o1_inst),
    .data_req(data_req), .data_rsp(o1_data), .mem_req(o1_mem), .mem_rsp(mem_rsp),
    .busy(o1_busy), .timeout(o1_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    inst_req = '0;
    data_req = '0;
  endtask

  task automatic set_req(input logic port, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] rd, input logic [3:0] wr);
    if (port) data_req = '{valid: 1'b1, addr: a, data: d, do_read: rd, do_write: wr};
    else inst_req = '{valid: 1'b1, addr: a, data: d, do_read: rd, do_write: wr};
  endtask

  task automatic pulse(input logic port, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] rd, input logic [3:0] wr);
    set_req(port, a, d, rd, wr);
    tick;
    clr;
  endtask

  task automatic wait_idle(input int n);
    logic done = 1'b0;
    for (int i = 0; i < n && !done; i++) begin
      tick;
      @(negedge clk);
      done = !o0_busy && rq.size() == 0 && r1q.size() == 0;
    end
    if (!done) chk("wait_idle_timeout", {o0_busy, rq.size() != 0}, 0);
    chk("issue_queue_drained", iq.size(), 0);
  endtask

  task automatic do_reset;
    g_flush = 1'b1;
    reset = 1'b1;
    clr;
    tick;
    tick;
    @(negedge clk);
    chk("rst_mem_req", o0_mem, 0);
    chk("rst_inst_rsp", o0_inst, RSP_RST);
    chk("rst_data_rsp", o0_data, RSP_RST);
    chk("rst_busy_timeout", {o0_busy, o0_to}, 0);
    tick;
    reset = 1'b0;
    g_flush = 1'b0;
  endtask

  task automatic tie(input logic inst_first);
    iss_t ii = '{addr: 32'h0, data: 32'h0, rd: 4'hF, wr: 4'h0};
    iss_t dd = '{addr: 32'h40, data: 32'h1234_5678, rd: 4'h0, wr: 4'h3};
    if (inst_first) begin
      iq.push_back(ii); iq.push_back(dd);
      rq.push_back('{port: 1'b0, data: g_rdata}); rq.push_back('{port: 1'b1, data: g_rdata});
    end else begin
      iq.push_back(dd); iq.push_back(ii);
      rq.push_back('{port: 1'b1, data: g_rdata}); rq.push_back('{port: 1'b0, data: g_rdata});
    end
    i1q.push_back(dd); i1q.push_back(ii);
    r1q.push_back(1'b1); r1q.push_back(1'b0);
    set_req(1'b0, ii.addr, ii.data, ii.rd, ii.wr);
    set_req(1'b1, dd.addr, dd.data, dd.rd, dd.wr);
    tick;
    clr;
    wait_idle(30);
  endtask

  initial begin
    iss_t e;
    rsp_t r;
    clr;
    mem_rsp = '{valid: 1'b0, ready: 1'b1, data: 32'd0};
    tbl[0] = '{1'b0, 32'h0000_0004, 32'h0, 4'hF, 4'h0, 1, 32'h1111_0004, 32'h1111_0004};
    tbl[1] = '{1'b1, 32'h0000_0080, 32'hA5A5_5A5A, 4'h0, 4'hF, 2, 32'h0000_0001, 32'h0000_0001};
    tbl[2] = '{1'b1, 32'h0000_0084, 32'h0, 4'h3, 4'h0, 3, 32'h0000_BEEF, 32'h0000_BEEF};
    tbl[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 4'h0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4] = '{1'b1, 32'h0000_0010, 32'h0F0F_0F0F, 4'h0, 4'h1, 4, 32'h0000_0077, 32'h0000_0077};
    fork
      begin : model
        int cnt;
        logic mv;
        cnt = 0;
        forever begin
          @(posedge clk);
          #2;
          mv = (cnt == 1 && !g_drop) || g_inject;
          if (cnt > 0) cnt--;
          if (g_flush) cnt = 0;
          mem_rsp = '{valid: mv, ready: g_ready, data: mv ? g_rdata : 32'd0};
          @(negedge clk);
          if (o0_mem.valid) cnt = g_lat;
        end
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (o0_mem.valid) begin
            if (iq.size() == 0) chk("issue_unexpected", o0_mem.valid, 0);
            else begin
              e = iq.pop_front();
              chk("issue_fields", {o0_mem.addr, o0_mem.data, o0_mem.do_read, o0_mem.do_write},
                  {e.addr, e.data, e.rd, e.wr});
            end
          end
          if (o0_inst.valid || o0_data.valid) begin
            chk("dual_rsp", o0_inst.valid && o0_data.valid, 0);
            if (rq.size() == 0) chk("rsp_unexpected", {o0_inst.valid, o0_data.valid}, 0);
            else begin
              r = rq.pop_front();
              chk("rsp_port", o0_data.valid, r.port);
              chk("rsp_data", o0_data.valid ? o0_data.data : o0_inst.data, r.data);
              chk("nonowner_data", o0_data.valid ? o0_inst.data : o0_data.data, 0);
            end
          end
          if (en1 && o1_mem.valid) begin
            if (i1q.size() == 0) chk("issue1_unexpected", o1_mem.valid, 0);
            else begin
              e = i1q.pop_front();
              chk("issue1_fields", {o1_mem.addr, o1_mem.data, o1_mem.do_read, o1_mem.do_write},
                  {e.addr, e.data, e.rd, e.wr});
            end
          end
          if (en1 && (o1_inst.valid || o1_data.valid)) begin
            if (r1q.size() == 0) chk("rsp1_unexpected", {o1_inst.valid, o1_data.valid}, 0);
            else chk("rsp1_port", {o1_inst.valid, o1_data.valid}, {!r1q[0], r1q[0]});
            if (r1q.size() != 0) void'(r1q.pop_front());
          end
        end
      end
    join_none

    do_reset;

    g_lat = 1;
    g_rdata = 32'hDEAD_BEEF;
    iq.push_back('{addr: 32'h100, data: 32'h0, rd: 4'hF, wr: 4'h0});
    rq.push_back('{port: 1'b0, data: 32'hDEAD_BEEF});
    set_req(1'b0, 32'h100, 32'h0, 4'hF, 4'h0);
    @(negedge clk);
    chk("fetch_ready_c0", o0_inst.ready, 1);
    tick;
    clr;
    @(negedge clk);
    chk("fetch_c1", {o0_inst.ready, o0_mem.valid, o0_busy}, 3'b001);
    tick;
    @(negedge clk);
    chk("fetch_c2_issue", {o0_mem.valid, o0_mem.addr, o0_mem.do_read}, {1'b1, 32'h100, 4'hF});
    tick;
    @(negedge clk);
    chk("fetch_c3_rsp", {o0_inst.valid, o0_inst.data, o0_data.valid}, {1'b1, 32'hDEAD_BEEF, 1'b0});
    tick;
    @(negedge clk);
    chk("fetch_c4_ready", {o0_inst.ready, o0_busy}, 2'b10);
    wait_idle(10);

    foreach (tbl[k]) begin
      g_lat = tbl[k].lat;
      g_rdata = tbl[k].rdata;
      iq.push_back('{addr: tbl[k].addr, data: tbl[k].wdata, rd: tbl[k].rd, wr: tbl[k].wr});
      rq.push_back('{port: tbl[k].port, data: tbl[k].exp_data});
      pulse(tbl[k].port, tbl[k].addr, tbl[k].wdata, tbl[k].rd, tbl[k].wr);
      wait_idle(20);
    end
    chk("no_timeout_late_rsp", o0_to, 0);

    g_lat = 1;
    g_rdata = 32'h600D_0600;
    iq.push_back('{addr: 32'h600, data: 32'h0, rd: 4'hF, wr: 4'h0});
    iq.push_back('{addr: 32'h604, data: 32'h0, rd: 4'hC, wr: 4'h0});
    rq.push_back('{port: 1'b0, data: 32'h600D_0600});
    rq.push_back('{port: 1'b1, data: 32'h600D_0600});
    pulse(1'b0, 32'h600, 32'h0, 4'hF, 4'h0);
    tick;
    tick;
    set_req(1'b1, 32'h604, 32'h0, 4'hC, 4'h0);
    @(negedge clk);
    chk("cc_done_and_free", {o0_inst.valid, o0_data.ready}, 2'b11);
    tick;
    clr;
    @(negedge clk);
    chk("cc_captured", {o0_data.ready, o0_inst.ready}, 2'b01);
    tick;
    @(negedge clk);
    chk("cc_issue", {o0_mem.valid, o0_mem.addr}, {1'b1, 32'h604});
    wait_idle(10);

    g_inject = 1'b1;
    @(negedge clk);
    chk("idle_rsp_ignored", {o0_inst.valid, o0_data.valid, o0_busy}, 0);
    tick;
    g_inject = 1'b0;

    do_reset;
    en1 = 1'b1;
    g_rdata = 32'hCAFE_0001;
    tie(1'b0);
    iq.push_back('{addr: 32'h44, data: 32'h0, rd: 4'hF, wr: 4'h0});
    i1q.push_back('{addr: 32'h44, data: 32'h0, rd: 4'hF, wr: 4'h0});
    rq.push_back('{port: 1'b1, data: g_rdata});
    r1q.push_back(1'b1);
    pulse(1'b1, 32'h44, 32'h0, 4'hF, 4'h0);
    wait_idle(20);
    tie(1'b1);
    tie(1'b1);
    chk("prio_idle", {o1_busy, o1_to, i1q.size() != 0}, 0);
    en1 = 1'b0;

    g_ready = 1'b0;
    g_rdata = 32'h5555_0500;
    iq.push_back('{addr: 32'h500, data: 32'h0, rd: 4'hF, wr: 4'h0});
    rq.push_back('{port: 1'b0, data: 32'h5555_0500});
    pulse(1'b0, 32'h500, 32'h0, 4'hF, 4'h0);
    tick;
    for (int k = 0; k < 5; k++) begin
      g_inject = k == 1;
      @(negedge clk);
      chk("stall_no_valid", o0_mem.valid, 0);
      chk("stall_ready_low", o0_inst.ready, 0);
      chk("stall_no_rsp", {o0_inst.valid, o0_data.valid}, 0);
      tick;
    end
    g_inject = 1'b0;
    g_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", o0_mem.valid, 1);
    tick;
    @(negedge clk);
    chk("stall_one_pulse", {o0_mem.valid, o0_inst.ready, o0_inst.valid}, 3'b001);
    wait_idle(10);

    g_drop = 1'b1;
    iq.push_back('{addr: 32'h200, data: 32'h0, rd: 4'hF, wr: 4'h0});
    rq.push_back('{port: 1'b0, data: 32'h0});
    pulse(1'b0, 32'h200, 32'h0, 4'hF, 4'h0);
    repeat (4) tick;
    @(negedge clk);
    chk("to_not_yet", {o0_inst.valid, o0_to}, 0);
    tick;
    @(negedge clk);
    chk("to_abort", {o0_inst.valid, o0_inst.data, o0_to}, {1'b1, 32'h0, 1'b0});
    tick;
    @(negedge clk);
    chk("to_set", {o0_to, o0_busy}, 2'b10);
    g_drop = 1'b0;
    g_rdata = 32'h0000_0300;
    iq.push_back('{addr: 32'h300, data: 32'h0, rd: 4'hF, wr: 4'h0});
    rq.push_back('{port: 1'b1, data: 32'h0000_0300});
    pulse(1'b1, 32'h300, 32'h0, 4'hF, 4'h0);
    wait_idle(20);
    chk("to_sticky", o0_to, 1);

    g_lat = 3;
    iq.push_back('{addr: 32'h700, data: 32'h0, rd: 4'hF, wr: 4'h0});
    pulse(1'b0, 32'h700, 32'h0, 4'hF, 4'h0);
    tick;
    tick;
    @(negedge clk);
    chk("rw_in_wait", {o0_busy, o0_inst.ready}, 2'b10);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("rw_mem_req", o0_mem, 0);
    chk("rw_inst_rsp", o0_inst, RSP_RST);
    chk("rw_data_rsp", o0_data, RSP_RST);
    chk("rw_busy_timeout", {o0_busy, o0_to}, 0);
    tick;
    @(negedge clk);
    chk("rw_late_dropped", {o0_inst.valid, o0_data.valid, o0_busy}, 0);
    tick;
    @(negedge clk);
    chk("rw_still_quiet", {o0_inst.valid, o0_data.valid, o0_busy}, 0);
    chk("rw_queues_empty", rq.size() + iq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
